// File: rtl/alu_issue_regfile_if.sv
// Instruction issue, register load, ALU operand/result and writeback signals
// between alu_issue_regfile (slave) and its driver/ALU (master).
interface alu_issue_regfile_if;
  localparam int unsigned DW = 4;
  localparam int unsigned AW = 2;
  localparam int unsigned SW = 3;
  localparam int unsigned IW = 9;
  localparam int unsigned CW = 8;

  logic          in_valid;
  logic [IW-1:0] in_instr;
  logic          in_ready;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] alu_rs;
  logic [DW-1:0] alu_rt;
  logic [SW-1:0] alu_sel;
  logic [DW-1:0] alu_rd;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic [CW-1:0] instr_count;

  modport master (
    output in_valid, in_instr, ld_valid, ld_addr, ld_data, alu_rd,
    input  in_ready, alu_rs, alu_rt, alu_sel, out_valid, out_addr, out_data, instr_count
  );

  modport slave (
    input  in_valid, in_instr, ld_valid, ld_addr, ld_data, alu_rd,
    output in_ready, alu_rs, alu_rt, alu_sel, out_valid, out_addr, out_data, instr_count
  );
endinterface

// File: rtl/alu_issue_regfile.sv
// Small register file that issues one ALU instruction at a time: operands are
// read and registered on accept, the ALU result is written back one edge later.
module alu_issue_regfile #(
  parameter int unsigned NREG = 4
) (
  input  logic               clk,
  input  logic               rst,
  alu_issue_regfile_if.slave bus
);
  localparam int unsigned DW = 4;
  localparam int unsigned AW = 2;
  localparam int unsigned SW = 3;
  localparam int unsigned CW = 8;

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] regs [NREG];
  logic [AW-1:0] rd_q;

  logic [SW-1:0] sel_c;
  logic [AW-1:0] rd_c;
  logic [AW-1:0] rs_c;
  logic [AW-1:0] rt_c;
  logic          in_ready_c;
  logic          load_c;
  logic          accept_c;

  assign {sel_c, rd_c, rs_c, rt_c} = bus.in_instr;
  assign bus.in_ready = in_ready_c;

  // Next state and handshake decode; loads win over a simultaneous instruction
  always_comb begin
    state_nxt  = state;
    in_ready_c = 1'b0;
    load_c     = 1'b0;
    accept_c   = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = !bus.ld_valid;
        load_c     = bus.ld_valid;
        accept_c   = bus.in_valid && !bus.ld_valid;
        if (accept_c) state_nxt = EXEC;
      end
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Register file, operand latch and writeback; reset in EXEC drops the result
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
      rd_q            <= '0;
      bus.alu_rs      <= '0;
      bus.alu_rt      <= '0;
      bus.alu_sel     <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_addr    <= '0;
      bus.out_data    <= '0;
      bus.instr_count <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      if (load_c) regs[bus.ld_addr] <= bus.ld_data;
      if (accept_c) begin
        bus.alu_sel <= sel_c;
        bus.alu_rs  <= regs[rs_c];
        bus.alu_rt  <= regs[rt_c];
        rd_q        <= rd_c;
      end
      if (state == EXEC) begin
        regs[rd_q]      <= bus.alu_rd;
        bus.out_valid   <= 1'b1;
        bus.out_addr    <= rd_q;
        bus.out_data    <= bus.alu_rd;
        bus.instr_count <= bus.instr_count + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_regfile.sv
// Directed bench for alu_issue_regfile with a behavioural Decode_And_Execute
// model feeding alu_rd from the registered operands.
module tb_alu_issue_regfile;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   exp_count;

  alu_issue_regfile_if bus ();

  alu_issue_regfile #(.NREG(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decode_And_Execute model
  always_comb begin
    case (bus.alu_sel)
      3'd0:    bus.alu_rd = bus.alu_rs - bus.alu_rt;
      3'd1:    bus.alu_rd = bus.alu_rs + bus.alu_rt;
      3'd2:    bus.alu_rd = bus.alu_rs | bus.alu_rt;
      3'd3:    bus.alu_rd = bus.alu_rs & bus.alu_rt;
      3'd4:    bus.alu_rd = bus.alu_rt >> 1;
      3'd5:    bus.alu_rd = {bus.alu_rs[2:0], bus.alu_rs[3]};
      3'd6:    bus.alu_rd = {3'b000, bus.alu_rs < bus.alu_rt};
      default: bus.alu_rd = {3'b000, bus.alu_rs == bus.alu_rt};
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [1:0] addr, input logic [3:0] data);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = addr;
    bus.ld_data  = data;
    tick();
    bus.ld_valid = 1'b0;
  endtask

  task automatic set_instr(input logic [2:0] sel, input logic [1:0] rd,
                           input logic [1:0] rs, input logic [1:0] rt);
    bus.in_instr = {sel, rd, rs, rt};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if ({bus.alu_rs, bus.alu_rt, bus.alu_sel} !== 11'd0) begin errors++; $display("FAIL reset_alu got %h/%h/%h exp 0/0/0", bus.alu_rs, bus.alu_rt, bus.alu_sel); end
    checks++; if ({bus.out_addr, bus.out_data} !== 6'd0) begin errors++; $display("FAIL reset_out got %h/%h exp 0/0", bus.out_addr, bus.out_data); end
    checks++; if (bus.instr_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.instr_count); end
    exp_count = 0;
  endtask

  task automatic test_add();
    do_load(2'd1, 4'd5);
    do_load(2'd2, 4'd3);
    bus.in_valid = 1'b1;
    set_instr(3'd1, 2'd3, 2'd1, 2'd2);
    tick();
    bus.in_valid = 1'b0;
    checks++; if ({bus.alu_rs, bus.alu_rt, bus.alu_sel} !== {4'd5, 4'd3, 3'd1}) begin errors++; $display("FAIL add_operands got %h/%h/%h exp 5/3/1", bus.alu_rs, bus.alu_rt, bus.alu_sel); end
    checks++; if ({bus.in_ready, bus.out_valid} !== 2'b00) begin errors++; $display("FAIL add_exec_flags got %b%b exp 00", bus.in_ready, bus.out_valid); end
    tick();
    exp_count++;
    checks++; if ({bus.out_valid, bus.out_addr, bus.out_data} !== {1'b1, 2'd3, 4'd8}) begin errors++; $display("FAIL add_writeback got %b/%h/%h exp 1/3/8", bus.out_valid, bus.out_addr, bus.out_data); end
    checks++; if (bus.instr_count !== 8'(exp_count)) begin errors++; $display("FAIL add_count got %0d exp %0d", bus.instr_count, exp_count); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_strobe_len got %b exp 0", bus.out_valid); end
    checks++; if ({bus.alu_rs, bus.alu_rt, bus.alu_sel} !== {4'd5, 4'd3, 3'd1}) begin errors++; $display("FAIL add_hold got %h/%h/%h exp 5/3/1", bus.alu_rs, bus.alu_rt, bus.alu_sel); end
    // Read back R3 through an OR of itself
    bus.in_valid = 1'b1;
    set_instr(3'd2, 2'd0, 2'd3, 2'd3);
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.alu_rs !== 4'd8) begin errors++; $display("FAIL add_r3_read got %h exp 8", bus.alu_rs); end
    tick();
    exp_count++;
  endtask

  task automatic test_back_to_back();
    do_load(2'd1, 4'd3);
    do_load(2'd2, 4'd5);
    bus.in_valid = 1'b1;
    set_instr(3'd0, 2'd0, 2'd1, 2'd2);
    tick();
    bus.in_valid = 1'b0;
    tick();
    exp_count++;
    checks++; if ({bus.out_valid, bus.out_addr, bus.out_data} !== {1'b1, 2'd0, 4'hE}) begin errors++; $display("FAIL sub_writeback got %b/%h/%h exp 1/0/e", bus.out_valid, bus.out_addr, bus.out_data); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", bus.in_ready); end
    bus.in_valid = 1'b1;
    set_instr(3'd7, 2'd1, 2'd0, 2'd0);
    tick();
    bus.in_valid = 1'b0;
    checks++; if ({bus.alu_rs, bus.alu_rt} !== {4'hE, 4'hE}) begin errors++; $display("FAIL b2b_raw got %h/%h exp e/e", bus.alu_rs, bus.alu_rt); end
    tick();
    exp_count++;
    checks++; if ({bus.out_valid, bus.out_addr, bus.out_data} !== {1'b1, 2'd1, 4'd1}) begin errors++; $display("FAIL eq_writeback got %b/%h/%h exp 1/1/1", bus.out_valid, bus.out_addr, bus.out_data); end
    checks++; if (bus.instr_count !== 8'(exp_count)) begin errors++; $display("FAIL b2b_count got %0d exp %0d", bus.instr_count, exp_count); end
  endtask

  task automatic test_load_priority();
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 2'd2;
    bus.ld_data  = 4'd9;
    bus.in_valid = 1'b1;
    set_instr(3'd1, 2'd3, 2'd2, 2'd2);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL prio_ready got %b exp 0", bus.in_ready); end
    tick();
    bus.ld_valid = 1'b0;
    #1;
    checks++; if ({bus.in_ready, bus.out_valid} !== 2'b10) begin errors++; $display("FAIL prio_idle got %b%b exp 10", bus.in_ready, bus.out_valid); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if ({bus.alu_rs, bus.alu_rt} !== {4'd9, 4'd9}) begin errors++; $display("FAIL prio_loaded got %h/%h exp 9/9", bus.alu_rs, bus.alu_rt); end
    tick();
    exp_count++;
    checks++; if ({bus.out_valid, bus.out_addr, bus.out_data} !== {1'b1, 2'd3, 4'd2}) begin errors++; $display("FAIL prio_writeback got %b/%h/%h exp 1/3/2", bus.out_valid, bus.out_addr, bus.out_data); end
  endtask

  task automatic test_streaming();
    do_load(2'd0, 4'd0);
    do_load(2'd1, 4'd1);
    bus.in_valid = 1'b1;
    set_instr(3'd1, 2'd0, 2'd0, 2'd1);
    #1;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) tick();
      checks++; if (bus.in_ready !== ((k % 2) == 0)) begin errors++; $display("FAIL stream_ready[%0d] got %b exp %b", k, bus.in_ready, (k % 2) == 0); end
      checks++; if (bus.out_valid !== ((k % 2) == 0 && k > 0)) begin errors++; $display("FAIL stream_valid[%0d] got %b exp %b", k, bus.out_valid, (k % 2) == 0 && k > 0); end
      if ((k % 2) == 0 && k > 0) begin
        exp_count++;
        checks++; if (bus.out_data !== 4'(k / 2)) begin errors++; $display("FAIL stream_data[%0d] got %h exp %h", k, bus.out_data, 4'(k / 2)); end
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.instr_count !== 8'(exp_count)) begin errors++; $display("FAIL stream_count got %0d exp %0d", bus.instr_count, exp_count); end
  endtask

  task automatic test_exec_ignores_load();
    do_load(2'd1, 4'd6);
    bus.in_valid = 1'b1;
    set_instr(3'd2, 2'd3, 2'd1, 2'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 2'd1;
    bus.ld_data  = 4'hF;
    tick();
    bus.ld_valid = 1'b0;
    exp_count++;
    checks++; if (bus.out_data !== 4'd6) begin errors++; $display("FAIL exec_or got %h exp 6", bus.out_data); end
    bus.in_valid = 1'b1;
    set_instr(3'd3, 2'd0, 2'd1, 2'd1);
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.alu_rs !== 4'd6) begin errors++; $display("FAIL exec_load_ignored got %h exp 6", bus.alu_rs); end
    tick();
    exp_count++;
  endtask

  task automatic test_reset_in_exec();
    do_load(2'd1, 4'd2);
    do_load(2'd2, 4'd4);
    bus.in_valid = 1'b1;
    set_instr(3'd1, 2'd2, 2'd1, 2'd1);
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_count = 0;
    checks++; if ({bus.out_valid, bus.out_addr, bus.out_data} !== 7'd0) begin errors++; $display("FAIL rstexec_out got %b/%h/%h exp 0/0/0", bus.out_valid, bus.out_addr, bus.out_data); end
    checks++; if ({bus.alu_rs, bus.alu_rt, bus.alu_sel} !== 11'd0) begin errors++; $display("FAIL rstexec_alu got %h/%h/%h exp 0/0/0", bus.alu_rs, bus.alu_rt, bus.alu_sel); end
    checks++; if ({bus.in_ready, bus.instr_count} !== {1'b1, 8'd0}) begin errors++; $display("FAIL rstexec_state got %b/%0d exp 1/0", bus.in_ready, bus.instr_count); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstexec_no_strobe got %b exp 0", bus.out_valid); end
    bus.in_valid = 1'b1;
    set_instr(3'd2, 2'd0, 2'd2, 2'd1);
    tick();
    bus.in_valid = 1'b0;
    checks++; if ({bus.alu_rs, bus.alu_rt} !== 8'd0) begin errors++; $display("FAIL rstexec_regs got %h/%h exp 0/0", bus.alu_rs, bus.alu_rt); end
    tick();
    exp_count++;
    checks++; if (bus.instr_count !== 8'(exp_count)) begin errors++; $display("FAIL rstexec_count got %0d exp %0d", bus.instr_count, exp_count); end
  endtask

  task automatic test_wrap();
    int pulses;
    pulses = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_instr(3'd1, 2'd0, 2'd0, 2'd1);
    for (int i = 0; i < 256; i++) begin
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      if (bus.out_valid === 1'b1) pulses++;
      if (i == 254) begin
        checks++; if (bus.instr_count !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d exp 255", bus.instr_count); end
      end
    end
    checks++; if (bus.instr_count !== 8'd0) begin errors++; $display("FAIL wrap_0 got %0d exp 0", bus.instr_count); end
    checks++; if (pulses != 256) begin errors++; $display("FAIL wrap_pulses got %0d exp 256", pulses); end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    exp_count    = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.ld_valid = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_data  = '0;
    test_reset();
    test_add();
    test_back_to_back();
    test_load_priority();
    test_streaming();
    test_exec_ignores_load();
    test_reset_in_exec();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
